// File: rtl/shift_sequencer.sv
// Iterative right shifter: one power-of-two shift level per clock, LSB level first, MSB fill from bit_shift_i.
// Latency: accept edge + LEVELS shift cycles; result and ready_o appear in the DONE cycle (LEVELS+1 cycles after the accept cycle).
// Backpressure: none downstream; start_i is ignored while busy_o is high (SHIFT and DONE), one op per LEVELS+2 cycles.
module shift_sequencer #(
  parameter int SWR    = 26,
  parameter int LEVELS = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [SWR-1:0]    Data_i,
  input  logic [LEVELS-1:0] Shift_Value_i,
  input  logic              bit_shift_i,
  output logic [SWR-1:0]    Data_o,
  output logic              busy_o,
  output logic              ready_o
);

  localparam int LVL_W = (LEVELS > 1) ? $clog2(LEVELS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [SWR-1:0]    work;
  logic [SWR-1:0]    work_lvl;
  logic [LEVELS-1:0] amount;
  logic              fill;
  logic [LVL_W-1:0]  lvl;
  logic [31:0]       step;
  logic              last_lvl;
  logic              accept;

  // A request is only taken from IDLE, which is exactly when busy_o is low.
  assign accept   = (state == IDLE) && start_i;
  assign last_lvl = (lvl == LVL_W'(LEVELS - 1));

  // One shift level: move right by 2**lvl when the matching amount bit is set.
  // A step of SWR or more drains the word completely into fill bits.
  always_comb begin
    step     = 32'd1 << lvl;
    work_lvl = work;
    if (amount[lvl]) begin
      work_lvl = work >> step;
      if (fill) begin
        work_lvl = work_lvl | ~({SWR{1'b1}} >> step);
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: fixed LEVELS-cycle SHIFT phase regardless of the amount.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_i)  state_nxt = SHIFT;
      SHIFT:   if (last_lvl) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from state; DONE is the single ready cycle.
  always_comb begin
    busy_o  = (state != IDLE);
    ready_o = (state == DONE);
  end

  // Datapath: capture on accept, shift one level per SHIFT cycle, publish the
  // final level straight into Data_o so it is valid during the DONE cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      work   <= '0;
      amount <= '0;
      fill   <= 1'b0;
      lvl    <= '0;
      Data_o <= '0;
    end else if (accept) begin
      work   <= Data_i;
      amount <= Shift_Value_i;
      fill   <= bit_shift_i;
      lvl    <= '0;
    end else if (state == SHIFT) begin
      work <= work_lvl;
      lvl  <= lvl + LVL_W'(1);
      if (last_lvl) begin
        Data_o <= work_lvl;
      end
    end
  end

endmodule
